// File: rtl/led_flow_multimode_if.sv
// led_flow_multimode_if: touch input and LED/status outputs of the flowing light.
`timescale 1ns/1ps
interface led_flow_multimode_if #(
    parameter int unsigned LED_NUM = 4
);
    logic               touch;
    logic [LED_NUM-1:0] led;
    logic [1:0]         mode;
    logic               running;

    modport master (output touch, input led, mode, running);
    modport slave  (input touch, output led, mode, running);
endinterface

// File: rtl/led_flow_multimode.sv
// led_flow_multimode: debounced touch drives a 4-mode LED pattern (flow/ping-pong/blink).
// Define LED_FLOW_AUTO_STOP_EN to stop the pattern after AUTO_STOP_STEPS steps.
`timescale 1ns/1ps
module led_flow_multimode #(
    parameter int unsigned LED_NUM         = 4,
    parameter logic [19:0] COUNT_MAX       = 20'd10,
    parameter logic [19:0] LONG_MAX        = 20'd50,
    parameter logic [23:0] STEP_MAX        = 24'd10,
    parameter logic [15:0] AUTO_STOP_STEPS = 16'd64
) (
    input  logic                 clk,
    input  logic                 reset,
    led_flow_multimode_if.slave  io
);
    localparam int CW = $clog2(COUNT_MAX);
    localparam int HW = $clog2(LONG_MAX);
    localparam int SW = $clog2(STEP_MAX);
    localparam int PW = $clog2(LED_NUM);
    localparam logic [PW-1:0] LAST = PW'(LED_NUM - 1);

    logic               s1_q, s2_q;
    logic               stable_q, stable_d;
    logic [CW-1:0]      db_q, db_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               long_done_q, long_done_d;
    logic [SW-1:0]      step_q, step_d;
    logic               run_q, run_d;
    logic [1:0]         mode_q, mode_d;
    logic [PW-1:0]      pos_q, pos_d, pp_nxt;
    logic               dir_q, dir_d;
    logic               phase_q, phase_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               flip, short_ev, long_ev, step_ev, adv, auto_stop;

    always_comb begin
        flip        = (s2_q != stable_q) && (db_q == CW'(COUNT_MAX - 1));
        stable_d    = flip ? s2_q : stable_q;
        db_d        = (s2_q == stable_q || flip) ? '0 : db_q + 1'b1;
        // a release edge beats a long classification landing on the same cycle
        short_ev    = flip && stable_q && !long_done_q;
        long_ev     = stable_q && !flip && !long_done_q &&
                      (hold_q == HW'(LONG_MAX - 1));
        hold_d      = hold_q;
        if (!stable_q)
            hold_d = '0;
        else if (hold_q != HW'(LONG_MAX - 1))
            hold_d = hold_q + 1'b1;
        long_done_d = stable_q && (long_done_q || long_ev);
    end

    always_comb begin
        step_ev = run_q && (step_q == SW'(STEP_MAX - 1));
        adv     = step_ev && !short_ev && !long_ev;
        run_d   = (run_q ^ short_ev) && !auto_stop;
        step_d  = (step_ev || long_ev || short_ev || !run_q) ? '0 : step_q + 1'b1;
        mode_d  = mode_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        pp_nxt  = dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
        if (long_ev) begin
            mode_d  = mode_q + 2'd1;
            pos_d   = '0;
            dir_d   = 1'b0;
            phase_d = 1'b0;
        end else if (adv) begin
            unique case (mode_q)
                2'd0: pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                2'd1: pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
                2'd2: begin
                    pos_d = pp_nxt;
                    if (pp_nxt == LAST)
                        dir_d = 1'b1;
                    else if (pp_nxt == '0)
                        dir_d = 1'b0;
                end
                2'd3: phase_d = ~phase_q;
            endcase
        end
    end

    always_comb begin
        led_d = '0;
        if (run_q) begin
            if (mode_q == 2'd3)
                led_d = phase_q ? '0 : '1;
            else
                led_d = LED_NUM'(1) << pos_q;
        end
    end

`ifdef LED_FLOW_AUTO_STOP_EN
    localparam int AW = $clog2(AUTO_STOP_STEPS) + 1;
    logic [AW-1:0] nstep_q, nstep_d;

    always_comb begin
        auto_stop = adv && (nstep_q == AW'(AUTO_STOP_STEPS - 1));
        nstep_d   = nstep_q;
        if (short_ev || long_ev || !run_q || auto_stop)
            nstep_d = '0;
        else if (adv)
            nstep_d = nstep_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            nstep_q <= '0;
        else
            nstep_q <= nstep_d;
    end
`else
    logic unused_auto;
    assign unused_auto = ^AUTO_STOP_STEPS;
    assign auto_stop   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            stable_q    <= 1'b0;
            db_q        <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            step_q      <= '0;
            run_q       <= 1'b0;
            mode_q      <= 2'd0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            phase_q     <= 1'b0;
            led_q       <= '0;
        end else begin
            s1_q        <= io.touch;
            s2_q        <= s1_q;
            stable_q    <= stable_d;
            db_q        <= db_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            step_q      <= step_d;
            run_q       <= run_d;
            mode_q      <= mode_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

    assign io.led     = led_q;
    assign io.mode    = mode_q;
    assign io.running = run_q;
endmodule

// File: tb/tb_led_flow_multimode.sv
// tb_led_flow_multimode: random bouncy presses against a step-timeline model,
// led and mode/running changes checked through scoreboard queues.
`timescale 1ns/1ps
module tb_led_flow_multimode;
    localparam int N  = 4;
    localparam int CM = 10;
    localparam int LM = 50;
    localparam int SM = 10;
    localparam int AS = 8;

    typedef struct {
        int t;
        bit lng;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    led_flow_multimode_if #(.LED_NUM(N)) io ();

    led_flow_multimode #(
        .LED_NUM(N),
        .COUNT_MAX(20'd10),
        .LONG_MAX(20'd50),
        .STEP_MAX(24'd10),
        .AUTO_STOP_STEPS(16'd8)
    ) dut (
        .clk(clk),
        .reset(rst),
        .io(io)
    );

    int pass_n = 0;
    int total  = 0;
    int cyc    = 0;
    ev_t evq[$];
    logic [N-1:0] exp_led_q[$];
    logic [2:0]   exp_mr_q[$];
    int m_mode, m_idx, m_base, m_nst;
    bit m_run;
    logic [N-1:0] last_led;
    logic [2:0]   last_mr;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            pass_n++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // pattern as a function of steps taken since the last mode change
    function automatic logic [N-1:0] led_of();
        int p, per;
        if (!m_run)
            return '0;
        if (m_mode == 3)
            return (m_idx % 2 == 1) ? '0 : '1;
        per = 2 * N - 2;
        case (m_mode)
            0: p = m_idx % N;
            1: p = (N - m_idx % N) % N;
            default: begin
                p = m_idx % per;
                if (p >= N)
                    p = per - p;
            end
        endcase
        return N'(1) << p;
    endfunction

    initial begin
        ev_t e;
        logic [N-1:0] nl;
        logic [2:0] mr;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_mode = 0; m_idx = 0; m_run = 0; m_base = cyc; m_nst = 0;
                evq.delete(); exp_led_q.delete(); exp_mr_q.delete();
                last_led = '0; last_mr = '0;
            end else begin
                if (evq.size() > 0 && evq[0].t == cyc) begin
                    e = evq.pop_front();
                    if (e.lng) begin
                        m_mode = (m_mode + 1) % 4;
                        m_idx  = 0;
                    end else begin
                        m_run = !m_run;
                    end
                    m_base = cyc;
                    m_nst  = 0;
                end else if (m_run && cyc > m_base && (cyc - m_base) % SM == 0) begin
                    m_idx++;
                    m_nst++;
`ifdef LED_FLOW_AUTO_STOP_EN
                    if (m_nst == AS)
                        m_run = 0;
`endif
                end
                nl = led_of();
                if (nl != last_led) begin
                    exp_led_q.push_back(nl);
                    last_led = nl;
                end
                mr = {m_mode[1:0], m_run};
                if (mr != last_mr) begin
                    exp_mr_q.push_back(mr);
                    last_mr = mr;
                end
            end
        end
    end

    initial begin
        logic [N-1:0] pl;
        logic [2:0] pmr;
        pl = '0;
        pmr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pl  = io.led;
                pmr = {io.mode, io.running};
            end else begin
                if (io.led != pl) begin
                    if (exp_led_q.size() == 0) begin
                        total++;
                        $display("FAIL led_unexpected: got %b with nothing expected", io.led);
                    end else begin
                        chk("led", int'(io.led), int'(exp_led_q.pop_front()));
                    end
                    pl = io.led;
                end
                if ({io.mode, io.running} != pmr) begin
                    if (exp_mr_q.size() == 0) begin
                        total++;
                        $display("FAIL mode_run_unexpected: got %b", {io.mode, io.running});
                    end else begin
                        chk("mode_run", int'({io.mode, io.running}), int'(exp_mr_q.pop_front()));
                    end
                    pmr = {io.mode, io.running};
                end
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit lng);
        int c, h;
        ev_t e;
        @(negedge clk);
        repeat ($urandom_range(0, 3)) begin
            io.touch = 1'b1; wait_n($urandom_range(1, 6));
            io.touch = 1'b0; wait_n($urandom_range(1, 6));
        end
        io.touch = 1'b1;
        c = cyc;
        h = lng ? $urandom_range(60, 80) : $urandom_range(12, 25);
        if (lng) begin
            e.t = c + 2 + CM + LM; e.lng = 1'b1;
            evq.push_back(e);
        end
        wait_n(h);
        repeat ($urandom_range(0, 2)) begin
            io.touch = 1'b0; wait_n($urandom_range(1, 5));
            io.touch = 1'b1; wait_n($urandom_range(1, 5));
        end
        io.touch = 1'b0;
        c = cyc;
        if (!lng) begin
            e.t = c + 2 + CM; e.lng = 1'b0;
            evq.push_back(e);
        end
        wait_n(2 + CM + 4);
    endtask

    task automatic long_timed(input string name);
        int c, old;
        ev_t e;
        old = m_mode;
        io.touch = 1'b1;
        c = cyc;
        e.t = c + 2 + CM + LM; e.lng = 1'b1;
        evq.push_back(e);
        wait_n(1 + CM + LM);
        chk({name, "_mode_before"}, int'(io.mode), old);
        wait_n(1);
        chk({name, "_mode_after"}, int'(io.mode), (old + 1) % 4);
        wait_n(70 - (2 + CM + LM));
        io.touch = 1'b0;
        wait_n(2 + CM + 4);
    endtask

    task automatic step_period();
        logic [N-1:0] p;
        int t0, n;
        p = io.led; n = 0;
        while (io.led == p && n < 4 * SM) begin @(negedge clk); n++; end
        t0 = cyc; p = io.led; n = 0;
        while (io.led == p && n < 4 * SM) begin @(negedge clk); n++; end
        chk("step_period", cyc - t0, SM);
    endtask

    initial begin
        bit exp_run;
        io.touch = 1'b0;
        repeat (3) begin
            @(negedge clk);
            io.touch = ~io.touch;
            chk("rst_led", int'(io.led), 0);
            chk("rst_mode", int'(io.mode), 0);
            chk("rst_running", int'(io.running), 0);
        end
        io.touch = 1'b0;
        rst = 1'b0;
        wait_n(5);

        press(1'b0);
        chk("first_press_running", int'(io.running), 1);
        step_period();
        wait_n($urandom_range(0, 9));
        long_timed("long1");
        step_period();
        // land the long event on the same edge as a step event
        while ((cyc + 2 + CM + LM - m_base) % SM != 0) @(negedge clk);
        long_timed("long_on_step");

        for (int i = 0; i < 24; i++) begin
            press($urandom_range(0, 2) == 0);
            wait_n($urandom_range(0, 60));
        end

        if (!m_run) press(1'b0);
        wait_n(100 * SM + 30);
`ifdef LED_FLOW_AUTO_STOP_EN
        exp_run = 1'b0;
`else
        exp_run = 1'b1;
`endif
        chk("run_after_100_steps", int'(io.running), int'(exp_run));

        if (m_run) press(1'b0);
        wait_n(30);
        chk("led_queue_drained", exp_led_q.size(), 0);
        chk("mode_queue_drained", exp_mr_q.size(), 0);

        press(1'b0);
        wait_n(25);
        chk("running_before_async_rst", int'(io.running), 1);
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        chk("async_rst_led", int'(io.led), 0);
        chk("async_rst_mode", int'(io.mode), 0);
        chk("async_rst_running", int'(io.running), 0);
        wait_n(3);
        rst = 1'b0;
        wait_n(3);
        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule

// File: doc/led_flow_multimode.md
Name: led_flow_multimode

Overview:
Parametrised successor to the touch-controlled 4-LED flowing light. It drives LED_NUM LEDs from one raw touch input, which is synchronised and debounced in the block. A short press toggles run/pause. A long press cycles through four display modes: flow-left, flow-right, ping-pong and blink-all. It sits at top level between the board button pin and the LED pins.

Parameters:
LED_NUM, 4, number of LEDs; must be ≥2.
COUNT_MAX, 20'd10, consecutive stable cycles required to accept a debounced level change.
LONG_MAX, 20'd50, debounced-high cycles that classify a press as long.
STEP_MAX, 24'd10, clock cycles per pattern step while running.
AUTO_STOP_STEPS, 16'd64, pattern steps before auto-stop; used only with the optional feature.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
touch  input  1  raw, bouncy, asynchronous button level (1 = pressed)
led  output  LED_NUM  LED drive (1 = on), registered
mode  output  2  current mode: 0 flow-left, 1 flow-right, 2 ping-pong, 3 blink
running  output  1  1 = pattern advancing

Behaviour:
- Reset (async, active-high; any time, including mid-press or mid-step):
  - led=0, mode=0, running=0.
  - pos=0, dir=up, blink phase=0.
  - Debounce state=0; all counters=0.
- Input path:
  - touch passes through a 2-FF synchroniser.
  - The debounce counter increments while the synchronised input differs from the stable level.
  - Any cycle where they match clears the counter. Glitches shorter than COUNT_MAX cycles are rejected.
  - When the counter reaches COUNT_MAX-1, the stable level takes the input value and the counter clears.
- Press classification:
  - The hold counter starts on the stable 0→1 edge.
  - Long press: the hold counter reaches LONG_MAX-1 while the stable level is still high. This fires one long event in that cycle. Releasing afterwards produces no event.
  - Short press: the stable 1→0 edge arrives before a long event. This fires one short event in the release cycle.
  - The hold counter saturates and does not wrap.
- Short event: running toggles on the next cycle. Pausing clears the step timer. pos, dir and phase are retained, so resume continues from the same position.
- Long event:
  - mode increments, wrapping 3→0.
  - pos=0, dir=up, phase=0, step timer cleared.
  - running is unchanged.
- Step timer:
  - Counts 0..STEP_MAX-1 only while running.
  - The wrap cycle is the step event, which advances the pattern.
- Pattern advance by mode:
  - 0 flow-left: pos+1, wrapping LED_NUM-1→0.
  - 1 flow-right: pos-1, wrapping 0→LED_NUM-1.
  - 2 ping-pong: move one position in dir. Flip dir on reaching 0 or LED_NUM-1. For LED_NUM=4 the sequence is 0,1,2,3,2,1,0,1…
  - 3 blink: phase toggles.
- led register, updated every cycle from the current state:
  - When running=0: all zeros.
  - Modes 0–2: one-hot at bit pos.
  - Mode 3: all ones when phase=0, all zeros when phase=1.
- Latency: an event is visible on led one cycle after the state register updates. Total latency from stable touch to led ≈ 2 + COUNT_MAX + 2 cycles.
- Simultaneous events:
  - A long event wins over a step event in the same cycle.
  - A short event that pauses wins over a step event; no advance occurs.
  - Short and long events are mutually exclusive by construction.
- Widths: counter widths are $clog2 of the corresponding MAX parameter. pos width is $clog2(LED_NUM).

Optional Feature:
- Macro: LED_FLOW_AUTO_STOP_EN.
- Defined:
  - A step counter counts step events while running.
  - The counter clears on any short or long event, and on pause.
  - When the counter reaches AUTO_STOP_STEPS, running is cleared and led goes to 0 on the next cycle. Position is retained.
- Undefined: no counter is built, and the pattern runs indefinitely.

Test Plan:
All scenarios use COUNT_MAX=10, LONG_MAX=50, STEP_MAX=10 and a 20 ns clock.

1. Reset: assert reset 60 ns with touch toggling → led=0000, running=0, mode=0 throughout. Assert reset asynchronously mid-run → outputs go to 0 immediately, with no clock edge needed.
2. Bouncy short press: touch high 40 ns, low 30 ns, high 300 ns, low 50 ns, high 30 ns, then low → exactly one short event. running=1. led sequence 0001→0010→0100→1000→0001, one step every 10 clocks.
3. Repeat the scenario-2 press 1000 ns later → running=0 and led=0000. A third press resumes from the retained pos; the next led is one-hot at the stored position, not 0001.
4. Long press: hold 70 clocks while running in mode 0 → mode=1 exactly LONG_MAX cycles after the debounced rise. led restarts at 0001, then 1000, 0100, … Release causes no run toggle.
5. Mode cycling: long presses into mode 2 → led 0001,0010,0100,1000,0100,0010,0001. Mode 3 → 1111/0000 alternating every 10 clocks. A further long press wraps mode to 0. Issue a long event on the same cycle as a step event → no advance; led=0001.
6. LED_FLOW_AUTO_STOP_EN, AUTO_STOP_STEPS=8 → running drops after the 8th step and led=0000. Without the macro → still running after 100 steps.
